// File: rtl/sumador_segmentado_pkg.sv
// Shared types and sizing helpers for the segmented adder.
// State encodings, mode codes and segment-count arithmetic.
package sumador_segmentado_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int seg_count(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sumador_segmento.sv
// One-bit full adder and the SEG-bit ripple slice built from it.
// The slice also exposes the carry into its MSB for overflow detection.
module sumador_completo #(
  parameter int PwrC = 0
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module sumador_segmento #(
  parameter int SEG  = 4,
  parameter int PwrC = 0
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    sumador_completo #(
      .PwrC(PwrC)
    ) u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(c[i+1])
    );
  end

  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/sumador_segmentado.sv
// Multi-cycle add/subtract: one SEG-bit slice per clock, carry kept
// in a register between slices, valid/ready on both sides.
module sumador_segmentado
  import sumador_segmentado_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int PwrC  = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = seg_count(WIDTH, SEG);
  localparam int IW = idx_width(N);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] s_nx;
  logic [IW-1:0]    idx;
  logic             carry_r;
  logic             co_r;
  logic             ovf_r;
  logic             zero_r;
  logic             valid_r;
  logic [SEG-1:0]   sl_a;
  logic [SEG-1:0]   sl_b;
  logic [SEG-1:0]   sl_s;
  logic             sl_co;
  logic             sl_cm;
  logic             last;

  always_comb begin
    sl_a = a_r[int'(idx)*SEG +: SEG];
    sl_b = b_r[int'(idx)*SEG +: SEG];
    last = (int'(idx) == N - 1);
    // Whole result as it will be once this slice lands; feeds zero.
    s_nx = s_r;
    s_nx[int'(idx)*SEG +: SEG] = sl_s;
  end

  sumador_segmento #(
    .SEG (SEG),
    .PwrC(PwrC)
  ) u_seg (
    .a    (sl_a),
    .b    (sl_b),
    .ci   (carry_r),
    .s    (sl_s),
    .co   (sl_co),
    .c_msb(sl_cm)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      idx     <= '0;
      carry_r <= 1'b0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= (mode == MODE_SUB) ? ~b : b;
            carry_r <= (mode == MODE_SUB) ? 1'b1 : ci;
            idx     <= '0;
          end
        end
        BUSY: begin
          s_r     <= s_nx;
          carry_r <= sl_co;
          idx     <= idx + 1'b1;
          if (last) begin
            co_r    <= sl_co;
            ovf_r   <= sl_cm ^ sl_co;
            zero_r  <= (s_nx == '0);
            valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) valid_r <= 1'b0;
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = valid_r;
  assign s         = s_r;
  assign co        = co_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_sumador_segmentado.sv
// Directed bench: three instances (SEG=4, 16, 1) share one stimulus
// stream; each must give the same result at its own latency.
module tb_sumador_segmentado;

  logic        clk;
  logic        reset_L;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        mode;
  logic        out_ready;

  logic        in_ready_o [3];
  logic        out_valid_o[3];
  logic [15:0] s_o        [3];
  logic        co_o       [3];
  logic        ovf_o      [3];
  logic        zero_o     [3];

  int n_checks;
  int n_fail;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    sumador_segmentado #(
      .WIDTH(16),
      .SEG  (k == 0 ? 4 : (k == 1 ? 16 : 1)),
      .PwrC (0)
    ) dut (
      .clk      (clk),
      .reset_L  (reset_L),
      .in_valid (in_valid),
      .in_ready (in_ready_o[k]),
      .a        (a),
      .b        (b),
      .ci       (ci),
      .mode     (mode),
      .out_valid(out_valid_o[k]),
      .out_ready(out_ready),
      .s        (s_o[k]),
      .co       (co_o[k]),
      .ovf      (ovf_o[k]),
      .zero     (zero_o[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
  endfunction

  task automatic run_op(input string nm,
                        input logic [15:0] va, input logic [15:0] vb,
                        input logic vci, input logic vmode,
                        input logic [15:0] es, input logic eco,
                        input logic eovf, input logic ez);
    int seen[3];
    seen = '{0, 0, 0};
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (in_ready_o[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_ready[%0d]: in_ready=%b expected 1", nm, k, in_ready_o[k]);
      end
    end
    in_valid = 1'b1; a = va; b = vb; ci = vci; mode = vmode;
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (seen[k] == 0 && out_valid_o[k] === 1'b1) seen[k] = e;
      if (seen[0] != 0 && seen[1] != 0 && seen[2] != 0) break;
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (seen[k] != lat_of(k)) begin
        n_fail++;
        $display("FAIL %s_lat[%0d]: latency=%0d expected %0d", nm, k, seen[k], lat_of(k));
      end
      n_checks++;
      if ({s_o[k], co_o[k], ovf_o[k], zero_o[k]} !== {es, eco, eovf, ez}) begin
        n_fail++;
        $display("FAIL %s[%0d]: s=%h co=%b ovf=%b zero=%b expected s=%h co=%b ovf=%b zero=%b",
                 nm, k, s_o[k], co_o[k], ovf_o[k], zero_o[k], es, eco, eovf, ez);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid_o[k] !== 1'b0 || in_ready_o[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_release[%0d]: out_valid=%b in_ready=%b expected 0 1",
                 nm, k, out_valid_o[k], in_ready_o[k]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_L = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; mode = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({in_ready_o[k], out_valid_o[k], s_o[k], co_o[k], ovf_o[k], zero_o[k]} !== {2'b10, 16'h0, 3'b000}) begin
        n_fail++;
        $display("FAIL reset[%0d]: rdy=%b vld=%b s=%h co=%b ovf=%b z=%b expected 1 0 0000 0 0 0",
                 k, in_ready_o[k], out_valid_o[k], s_o[k], co_o[k], ovf_o[k], zero_o[k]);
      end
    end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_add;
    run_op("add_chain", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    run_op("wrap_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("wrap_ci",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_subtract;
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_plain",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h0FCD; ci = 1'b0; mode = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; mode = 1'b1;
    repeat (17) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({out_valid_o[k], in_ready_o[k], s_o[k], co_o[k], ovf_o[k], zero_o[k]} !== {2'b10, 16'h2201, 3'b000}) begin
          n_fail++;
          $display("FAIL hold_c%0d[%0d]: vld=%b rdy=%b s=%h co=%b ovf=%b z=%b expected 1 0 2201 0 0 0",
                   c, k, out_valid_o[k], in_ready_o[k], s_o[k], co_o[k], ovf_o[k], zero_o[k]);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid_o[k] !== 1'b0 || in_ready_o[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_release[%0d]: out_valid=%b in_ready=%b expected 0 1",
                 k, out_valid_o[k], in_ready_o[k]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h0FCD; ci = 1'b0; mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({in_ready_o[k], out_valid_o[k], s_o[k], co_o[k], ovf_o[k], zero_o[k]} !== {2'b10, 16'h0, 3'b000}) begin
        n_fail++;
        $display("FAIL midop_reset[%0d]: rdy=%b vld=%b s=%h co=%b ovf=%b z=%b expected 1 0 0000 0 0 0",
                 k, in_ready_o[k], out_valid_o[k], s_o[k], co_o[k], ovf_o[k], zero_o[k]);
      end
    end
    @(negedge clk);
    reset_L = 1'b1;
    run_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_wrap();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sumador_segmentado.md
Name: sumador_segmentado

Overview:
- Parametrised, multi-cycle successor to the 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands, SEG bits per clock, with one registered carry between segments.
- Trades latency for a short critical path and lower switching activity.
- Sits in the power-analysis datapath behind a valid/ready handshake and reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SEG.
- SEG, 4, bits added per cycle; 1 <= SEG <= WIDTH.
- PwrC, 0, power-count tag passed unchanged to gate-level primitives.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in, add mode only.
- mode  input  1  0 = add (a+b+ci), 1 = subtract (a+~b+1, ci ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  registered sum/difference.
- co  output  1  carry out of MSB; in subtract mode, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  s == 0.

Behaviour:
- Reset (reset_L low, asynchronous):
  - state = IDLE; s, co, ovf, zero, out_valid, segment index and carry register all 0.
  - in_ready = 1 (it is decoded from IDLE).
  - Reset aborts any operation in flight; the partial result is discarded.
- States: IDLE, BUSY, DONE. N = WIDTH/SEG.
- IDLE:
  - in_ready = 1.
  - When in_valid is high on a clock edge:
    - latch a into A_r; latch mode-adjusted b (b, or ~b when mode=1) into B_r;
    - carry register = ci if mode=0, 1 if mode=1;
    - segment index = 0; go to BUSY.
- BUSY:
  - in_ready = 0; inputs are ignored.
  - Each cycle, the segment slice adds bits [idx*SEG +: SEG] of A_r and B_r with the carry register.
  - The slice result is written into s at that slice; carry register = slice carry-out; idx increments.
  - On the cycle where idx = N-1:
    - co = slice carry-out;
    - ovf = carry into bit WIDTH-1 XOR slice carry-out;
    - zero = (final s == 0), evaluated on the complete result including the segment being written;
    - out_valid <= 1; go to DONE.
- DONE:
  - out_valid = 1; s, co, ovf and zero are held stable; in_ready = 0.
  - When out_ready is high: out_valid <= 0, go to IDLE.
  - No new operand is accepted in the same cycle.
- Latency and throughput:
  - out_valid rises N clock edges after the accept edge.
  - Throughput is one operation per N+2 cycles with out_ready held high.
  - SEG = WIDTH gives latency 1.
- s bits belonging to segments not yet written during BUSY are don't-care; the bench checks s only while out_valid = 1.
- in_valid in BUSY or DONE is ignored; there is no queueing.
- out_ready while not in DONE has no effect.
- Arithmetic is modulo 2^WIDTH. There is no saturation; a carry register is all that is kept between segments.

Decomposition:
- Shared package/header:
  - state encodings IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  - MODE_ADD = 1'b0, MODE_SUB = 1'b1;
  - derived N and the index width clog2(N), minimum 1.
- One sub-module: sumador_segmento.
  - Combinational SEG-bit ripple slice built from a chain of the existing one-bit full adder (PwrC passed through).
  - Outputs: SEG-bit sum, carry-out, and carry into the slice MSB (used for ovf).
- The top level holds the FSM, operand registers, segment index, carry register and flag registers.

Test Plan (WIDTH=16, SEG=4 unless noted):
- Add with carry chain: a=0x1234, b=0x0FCD, ci=0, mode=0 -> s=0x2201, co=0, ovf=0, zero=0; out_valid exactly 4 edges after accept.
- Wrap to zero: a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, zero=1, ovf=0. Repeat with ci=1 -> s=0x0001, co=1, zero=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> s=0x8000, ovf=1, co=0. Then a=0x8000, b=0x8000 -> s=0x0000, co=1, ovf=1, zero=1.
- Subtract: mode=1, a=0x0005, b=0x0007, ci=1 (must be ignored) -> s=0xFFFE, co=0, ovf=0. Then a=0x0007, b=0x0005 -> s=0x0002, co=1.
- Backpressure/ignore:
  - Hold out_ready=0 for 3 cycles in DONE -> s and flags stable, in_ready=0.
  - in_valid pulsed in BUSY and DONE with other operands -> no effect on result.
  - out_ready=1 -> out_valid falls next edge, in_ready=1.
- Reset mid-op and parameter sweep:
  - Drop reset_L asynchronously in BUSY idx=2 -> all outputs 0 immediately, in_ready=1; the next op 0x00FF+0x0001 gives s=0x0100.
  - Rerun the scenarios with SEG=16 (latency 1) and SEG=1 (latency 16) -> identical results.
